mem_port_responder: RTL
=======================

Name: mem_port_responder

Overview:
- Slave-side stand-in for dram_control on the 128-bit valid/ready memory port.
- Accepts one line read or line write per handshake and stores lines in an on-chip array.
- Returns ready after a programmable latency.
- Used for FPGA bring-up and simulation of port initiators (test drivers, cache refill logic) without a DDR3 device.

Parameters:
- DEPTH_LOG2, 8, number of 128-bit lines = 2**DEPTH_LOG2.
- LATENCY, 4, WAIT cycles between accept and ready; legal range 1..255.
- INIT_ZERO, 1, when 1 the array is preloaded with zeros (initial block); when 0 contents are undefined.

Ports:
- clk, input, 1, clock.
- reset, input, 1, reset.
- valid, input, 1, request present; initiator holds it until the handshake.
- ready, output, 1, one-cycle completion pulse; valid & ready = transaction done.
- addr, input, 32, byte address; line index = addr[4 +: DEPTH_LOG2].
- wmask, input, 1, 1 = write line, 0 = read line.
- wdata, input, 128, write data.
- rdata, output, 128, read data; valid in the ready cycle.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values: ready=0, rdata=0, state=IDLE, wait counter=0. Array contents are not cleared by reset.
- States:
  - IDLE: valid=1 at a clock edge → capture addr index, wmask, wdata; load cnt=LATENCY-1; go to WAIT.
  - WAIT: if cnt!=0, decrement and stay. If cnt==0 → go to RESP and register ready=1.
    - Read: also register rdata=mem[idx] on this edge.
    - Write: mem[idx]=wdata_captured on this edge; rdata unchanged.
  - RESP: ready=1 for exactly this cycle; next edge → IDLE, ready=0.
- Latency: valid first high in cycle 0 → ready high in cycle LATENCY+1. For LATENCY=4, ready is high in cycle 5.
- Capture rules: addr, wmask and wdata are sampled only at the IDLE accept edge. Changes after acceptance are ignored.
- valid dropping before ready is a protocol violation. The captured transaction still completes and ready still pulses.
- Back-to-back: valid high in the cycle after ready (IDLE) is accepted immediately. No idle gap is required.
- Read-after-write: a read accepted after a write's ready returns the new data.
- Address bits [3:0] and bits above 4+DEPTH_LOG2 are ignored; out-of-range addresses alias (wrap).
- Reset mid-operation (WAIT or RESP): return to IDLE, ready=0, rdata=0. A pending write is discarded and the array is not modified.
- Only one outstanding transaction; no queueing.

Optional Feature:
- Macro: MEM_RESP_JITTER_EN.
- Defined:
  - 8-bit LFSR, taps x^8+x^6+x^5+x^4+1, seeded 8'hA5 on reset, advances once per accept.
  - At accept, cnt=LATENCY-1+lfsr[1:0], so ready lands in cycles LATENCY+1 .. LATENCY+4.
  - The LFSR value is deterministic after reset, for repeatable tests.
- Undefined: fixed latency as above; no LFSR logic is instantiated.

Decomposition:
- mem_resp_pkg holds:
  - line width constant LINE_W=128 and offset bits LINE_OFS=4;
  - state enum {IDLE, WAIT, RESP};
  - LFSR seed and tap constants.
- One sub-module: mem_resp_ram, a single-port array with synchronous write and synchronous read-enable. Ports: clk, we, re, idx, din, dout; parameter DEPTH_LOG2.
- FSM, capture registers, counter and optional LFSR stay in mem_port_responder.

Test Plan:
- Write then read: write wdata=128'h1 to addr 0x100, then read 0x100 → rdata=128'h1 in the ready cycle. Ready is high in cycle 5 after each valid rise (LATENCY=4), and is a single-cycle pulse each time.
- Tester loop: drive the write/read/increment pattern for 20 iterations → the final read returns 128'd20; no ready when valid=0.
- Aliasing: write 128'hDEAD to 0x100, read 0x10F and 0x1100 (DEPTH_LOG2=8) → both return 128'hDEAD. Read 0x110 → 0 with INIT_ZERO=1.
- Reset mid-write: accept a write of 128'h55 to 0x200, assert reset in WAIT cycle 2, then read 0x200 → 0. ready stays low during and after reset until the new handshake.
- Capture stability: accept a read of 0x100, then change addr to 0x300 and wmask to 1 during WAIT → the read of 0x100 data completes and line 0x300 is unmodified.
- With MEM_RESP_JITTER_EN: 16 reads after reset → every latency lies in 5..8 cycles, and the sequence matches the LFSR model seeded 8'hA5.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared constants and types for the memory port responder.
// LFSR constants are only consumed when MEM_RESP_JITTER_EN is defined.
package mem_resp_pkg;

  localparam int LINE_W   = 128;  // one cache line per transfer
  localparam int LINE_OFS = 4;    // byte offset bits inside a line

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // x^8 + x^6 + x^5 + x^4 + 1, shifting left: feedback from bits 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mem_port_responder_if.sv
// 128-bit valid/ready memory port. The initiator holds valid and the request
// fields until the single-cycle ready pulse completes the transfer.
interface mem_port_responder_if;
  import mem_resp_pkg::*;

  logic              valid;
  logic              ready;
  logic [31:0]       addr;
  logic              wmask;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;

  modport master (output valid, output addr, output wmask, output wdata,
                  input  ready, input  rdata);
  modport slave  (input  valid, input  addr, input  wmask, input  wdata,
                  output ready, output rdata);
endinterface

// File: rtl/mem_resp_ram.sv
// Single-port line store: synchronous write, registered read under re.
// INIT_ZERO=1 gives a zero-filled power-up image; otherwise contents are
// left undefined.
module mem_resp_ram
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int INIT_ZERO  = 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [LINE_W-1:0]     din,
  output logic [LINE_W-1:0]     dout
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  if (INIT_ZERO != 0) begin : g_zero
    logic [LINE_W-1:0] mem [DEPTH] = '{default: '0};

    // write port and registered read port share the single index
    always_ff @(posedge clk) begin
      if (we) mem[idx] <= din;
      if (re) dout <= mem[idx];
    end
  end else begin : g_undef
    logic [LINE_W-1:0] mem [DEPTH];

    // write port and registered read port share the single index
    always_ff @(posedge clk) begin
      if (we) mem[idx] <= din;
      if (re) dout <= mem[idx];
    end
  end

endmodule

// File: rtl/mem_port_responder.sv
// Slave-side stand-in for dram_control: one line read/write per handshake,
// ready pulses after a programmable latency.
// Optional MEM_RESP_JITTER_EN adds 0..3 extra wait cycles from an LFSR.
module mem_port_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 4,
  parameter int INIT_ZERO  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_responder_if.slave  bus
);

  // LATENCY up to 255 plus up to 3 jitter cycles
  localparam int CNT_W = 9;

  state_t                state, state_nxt;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  wr_q;
  logic [LINE_W-1:0]     wdata_q;
  logic [LINE_W-1:0]     rdata_q;
  logic [LINE_W-1:0]     ram_dout;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_load;
  logic                  accept;
  logic                  done;
  logic                  ram_we;
  logic                  ram_re;
  logic                  unused_addr;

  assign unused_addr = ^{bus.addr[31:LINE_OFS+DEPTH_LOG2], bus.addr[LINE_OFS-1:0]};

  assign accept = (state == IDLE) && bus.valid;
  assign done   = (state == WAIT) && (cnt_q == '0);
  // gating with reset drops a write that would land on the reset edge
  assign ram_we = done && wr_q && !reset;
  assign ram_re = done && !wr_q && !reset;

`ifdef MEM_RESP_JITTER_EN
  logic [7:0] lfsr_q;

  // LFSR steps once per accept so the jitter sequence is repeatable
  always_ff @(posedge clk) begin
    if (reset)       lfsr_q <= LFSR_SEED;
    else if (accept) lfsr_q <= lfsr_next(lfsr_q);
  end

  assign cnt_load = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_q[1:0]);
`else
  assign cnt_load = CNT_W'(LATENCY - 1);
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.valid) state_nxt = WAIT;
      WAIT:    if (cnt_q == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // request capture, wait counter and held read data
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        idx_q   <= bus.addr[LINE_OFS +: DEPTH_LOG2];
        wr_q    <= bus.wmask;
        wdata_q <= bus.wdata;
        cnt_q   <= cnt_load;
      end else if ((state == WAIT) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if ((state == RESP) && !wr_q) rdata_q <= ram_dout;
    end
  end

  mem_resp_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .INIT_ZERO  (INIT_ZERO)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .idx  (idx_q),
    .din  (wdata_q),
    .dout (ram_dout)
  );

  // RAM output registered on the WAIT->RESP edge is visible in the ready
  // cycle, then held in rdata_q until the next read completes
  assign bus.ready = (state == RESP);
  assign bus.rdata = ((state == RESP) && !wr_q) ? ram_dout : rdata_q;

endmodule
